// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a console FIFO one byte at a time and
// serialises each byte as a start / LSB-first data / stop-bit frame.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 104,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_advance,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  localparam int BAUD_W = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [BAUD_W-1:0] BIT_END  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] STOP_END = BAUD_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] STOP_PRE = BAUD_W'(STOP_BITS * CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0]  IDX_END  = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t             state_reg, state_next;
  logic [BAUD_W-1:0]  baud_reg, baud_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [WIDTH-1:0]   shift_reg, shift_next;
  logic               tx_reg, tx_next;
  logic               busy_reg, busy_next;
  logic               adv_reg, adv_next;
  logic               done_reg, done_next;

  logic start_frame;
  logic bit_end;
  logic stop_end;

  assign start_frame = enable && !fifo_empty;
  assign bit_end     = (baud_reg == BIT_END);
  assign stop_end    = (baud_reg == STOP_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      adv_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      adv_reg   <= adv_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_frame) state_next = SETTLE;
      SETTLE:  state_next = LOAD;
      LOAD:    state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && idx_reg == IDX_END) state_next = STOP;
      STOP:    if (stop_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values for every registered output and datapath register.
  always_comb begin
    baud_next  = baud_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
    busy_next  = busy_reg;
    adv_next   = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        tx_next   = 1'b1;
        busy_next = start_frame;
        baud_next = '0;
      end
      SETTLE: begin
        adv_next = 1'b1;
      end
      LOAD: begin
        // The FIFO advances on this edge; fifo_data still holds the old head.
        shift_next = fifo_data;
        tx_next    = 1'b0;
        baud_next  = '0;
      end
      START: begin
        if (bit_end) begin
          baud_next  = '0;
          idx_next   = '0;
          tx_next    = shift_reg[0];
          shift_next = shift_reg >> 1;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_next = '0;
          if (idx_reg == IDX_END) begin
            tx_next = 1'b1;
          end else begin
            idx_next   = idx_reg + 1'b1;
            tx_next    = shift_reg[0];
            shift_next = shift_reg >> 1;
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      STOP: begin
        tx_next   = 1'b1;
        done_next = (baud_reg == STOP_PRE);
        if (stop_end) begin
          baud_next = '0;
          busy_next = 1'b0;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      default: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        baud_next = '0;
      end
    endcase
  end

  assign fifo_advance = adv_reg;
  assign tx           = tx_reg;
  assign busy         = busy_reg;
  assign tx_done      = done_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (one and two stop bits), each fed by
// a small FIFO model, checked cycle by cycle against a frame-timing model.
module tb_fifo_uart_tx;

  localparam int W = 8;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en1 = 1'b0, en2 = 1'b0;
  logic fempty1 = 1'b1, fempty2 = 1'b1;
  logic [W-1:0] fdata1 = '0, fdata2 = '0;
  logic adv1, tx1, busy1, done1;
  logic adv2, tx2, busy2, done2;

  logic [W-1:0] mem1 [16];
  logic [W-1:0] mem2 [16];
  logic [3:0] rd1 = '0, wr1 = '0, rd2 = '0, wr2 = '0;
  logic [W-1:0] exp_bytes [8];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(C), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en1), .fifo_empty(fempty1),
    .fifo_data(fdata1), .fifo_advance(adv1), .tx(tx1), .busy(busy1),
    .tx_done(done1)
  );

  fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(en2), .fifo_empty(fempty2),
    .fifo_data(fdata2), .fifo_advance(adv2), .tx(tx2), .busy(busy2),
    .tx_done(done2)
  );

  // Registered FIFO read side: head data lags the read pointer by one cycle.
  always @(posedge clk) begin
    fdata1  <= mem1[rd1];
    if (adv1) rd1 <= rd1 + 4'd1;
    fempty1 <= ((adv1 ? rd1 + 4'd1 : rd1) == wr1);
    fdata2  <= mem2[rd2];
    if (adv2) rd2 <= rd2 + 4'd1;
    fempty2 <= ((adv2 ? rd2 + 4'd1 : rd2) == wr2);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [W-1:0] b);
    mem1[wr1] = b;
    wr1 = wr1 + 4'd1;
  endtask

  task automatic push2(input logic [W-1:0] b);
    mem2[wr2] = b;
    wr2 = wr2 + 4'd1;
  endtask

  // Line level k cycles into a frame: start, LSB-first data, then stop.
  function automatic logic frame_bit(input logic [W-1:0] b, input int k);
    if (k < C) return 1'b0;
    if (k < (1 + W) * C) return b[k / C - 1];
    return 1'b1;
  endfunction

  // Expected {tx,busy,advance,done} t cycles after the first empty=0 sample,
  // for nf queued bytes; each frame costs settle+load+frame+one idle cycle.
  function automatic logic [3:0] exp_obs(input int t, input int nf, input int s);
    int f, p, i, r, k;
    logic [3:0] o;
    f = (1 + W + s) * C;
    p = f + 3;
    i = t / p;
    r = t % p;
    o = 4'b1000;
    if (i < nf) begin
      if (r < 2) begin
        o = {1'b1, 1'b1, (r == 1), 1'b0};
      end else if (r < f + 2) begin
        k = r - 2;
        o = {frame_bit(exp_bytes[i], k), 1'b1, 1'b0, (k == f - 1)};
      end
    end
    return o;
  endfunction

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx1, busy1, adv1, done1} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_async1 got=%b required=1000", {tx1, busy1, adv1, done1});
    end
    checks++;
    if ({tx2, busy2, adv2, done2} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_async2 got=%b required=1000", {tx2, busy2, adv2, done2});
    end
    push1(8'hA5);
    en1 = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step();
      checks++;
      if ({tx1, busy1, adv1, done1} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_hold n=%0d got=%b required=1000", n, {tx1, busy1, adv1, done1});
      end
    end
  endtask

  task automatic test_single_byte;
    int nbusy, nadv, ndone;
    logic [3:0] e;
    nbusy = 0; nadv = 0; ndone = 0;
    exp_bytes[0] = 8'hA5;
    rst_n = 1'b1;
    for (int t = 0; t < 60; t++) begin
      step();
      e = exp_obs(t, 1, 1);
      nbusy += int'(busy1); nadv += int'(adv1); ndone += int'(done1);
      checks++;
      if ({tx1, busy1, adv1, done1} !== e) begin
        errors++;
        $display("FAIL single t=%0d got(tx,busy,adv,done)=%b required=%b", t, {tx1, busy1, adv1, done1}, e);
      end
    end
    checks++;
    if (nbusy != 42) begin errors++; $display("FAIL single_busy got=%0d required=42", nbusy); end
    checks++;
    if (nadv != 1) begin errors++; $display("FAIL single_adv got=%0d required=1", nadv); end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL single_done got=%0d required=1", ndone); end
  endtask

  task automatic test_back_to_back;
    int nadv;
    logic [3:0] e;
    nadv = 0;
    exp_bytes[0] = 8'h00;
    exp_bytes[1] = 8'hFF;
    push2(8'h00);
    push2(8'hFF);
    en2 = 1'b1;
    step();
    for (int t = 0; t < 2 * 47 + 8; t++) begin
      step();
      e = exp_obs(t, 2, 2);
      nadv += int'(adv2);
      checks++;
      if ({tx2, busy2, adv2, done2} !== e) begin
        errors++;
        $display("FAIL b2b t=%0d got(tx,busy,adv,done)=%b required=%b", t, {tx2, busy2, adv2, done2}, e);
      end
    end
    checks++;
    if (nadv != 2) begin errors++; $display("FAIL b2b_adv got=%0d required=2", nadv); end
    en2 = 1'b0;
  endtask

  task automatic test_enable_gate;
    logic [3:0] e;
    en1 = 1'b0;
    exp_bytes[0] = 8'h6E;
    push1(8'h6E);
    for (int n = 0; n < 50; n++) begin
      step();
      checks++;
      if ({tx1, busy1, adv1, done1} !== 4'b1000) begin
        errors++;
        $display("FAIL gate_hold n=%0d got=%b required=1000", n, {tx1, busy1, adv1, done1});
      end
    end
    en1 = 1'b1;
    for (int t = 0; t < 48; t++) begin
      step();
      e = exp_obs(t, 1, 1);
      checks++;
      if ({tx1, busy1, adv1, done1} !== e) begin
        errors++;
        $display("FAIL gate_frame t=%0d got(tx,busy,adv,done)=%b required=%b", t, {tx1, busy1, adv1, done1}, e);
      end
    end
  endtask

  task automatic test_enable_drop;
    logic [3:0] e;
    exp_bytes[0] = 8'h3C;
    push1(8'h3C);
    push1(8'h55);
    en1 = 1'b1;
    step();
    for (int t = 0; t < 43 + 30; t++) begin
      step();
      e = exp_obs(t, 1, 1);
      checks++;
      if ({tx1, busy1, adv1, done1} !== e) begin
        errors++;
        $display("FAIL drop t=%0d got(tx,busy,adv,done)=%b required=%b", t, {tx1, busy1, adv1, done1}, e);
      end
      if (t == 2 + 3 * C) en1 = 1'b0;
    end
    checks++;
    if (4'(wr1 - rd1) != 4'd1) begin
      errors++;
      $display("FAIL drop_left got=%0d required=1", 4'(wr1 - rd1));
    end
    wr1 = rd1;
    step();
    step();
  endtask

  task automatic test_reset_mid_frame;
    logic [3:0] e;
    exp_bytes[0] = 8'h5A;
    push1(8'h5A);
    push1(8'h81);
    en1 = 1'b1;
    step();
    for (int t = 0; t < 20; t++) begin
      step();
      e = exp_obs(t, 1, 1);
      checks++;
      if ({tx1, busy1, adv1, done1} !== e) begin
        errors++;
        $display("FAIL mid_pre t=%0d got(tx,busy,adv,done)=%b required=%b", t, {tx1, busy1, adv1, done1}, e);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx1, busy1, adv1, done1} !== 4'b1000) begin
      errors++;
      $display("FAIL mid_async got=%b required=1000", {tx1, busy1, adv1, done1});
    end
    for (int n = 0; n < 3; n++) begin
      step();
      checks++;
      if ({tx1, busy1, adv1, done1} !== 4'b1000) begin
        errors++;
        $display("FAIL mid_hold n=%0d got=%b required=1000", n, {tx1, busy1, adv1, done1});
      end
    end
    rst_n = 1'b1;
    exp_bytes[0] = 8'h81;
    for (int t = 0; t < 43 + 10; t++) begin
      step();
      e = exp_obs(t, 1, 1);
      checks++;
      if ({tx1, busy1, adv1, done1} !== e) begin
        errors++;
        $display("FAIL mid_post t=%0d got(tx,busy,adv,done)=%b required=%b", t, {tx1, busy1, adv1, done1}, e);
      end
    end
    checks++;
    if (rd1 !== wr1) begin errors++; $display("FAIL mid_drain rd=%0d required=%0d", rd1, wr1); end
  endtask

  task automatic test_random;
    int nb;
    logic [3:0] e;
    for (int it = 0; it < 3; it++) begin
      nb = int'($urandom_range(2, 4));
      for (int i = 0; i < nb; i++) begin
        exp_bytes[i] = W'($urandom);
        push1(exp_bytes[i]);
      end
      en1 = 1'b1;
      step();
      for (int t = 0; t < nb * 43 + 4; t++) begin
        step();
        e = exp_obs(t, nb, 1);
        checks++;
        if ({tx1, busy1, adv1, done1} !== e) begin
          errors++;
          $display("FAIL random it=%0d t=%0d got(tx,busy,adv,done)=%b required=%b", it, t, {tx1, busy1, adv1, done1}, e);
        end
      end
      checks++;
      if (rd1 !== wr1) begin errors++; $display("FAIL random_drain rd=%0d required=%0d", rd1, wr1); end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_enable_gate();
    test_enable_drop();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
